// File: rtl/pc_trace_monitor.sv
// Passive PC stream monitor: classifies each accepted PC as sequential, stall or jump,
// keeps saturating event counters and flags boot-PC, alignment and hang conditions.
module pc_trace_monitor #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              HANG_LIMIT = 16,
    parameter int              CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [PC_W-1:0]  PC_IN,
    output logic [PC_W-1:0]  LAST_PC,
    output logic [CNT_W-1:0] SEQ_CNT,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] JUMP_CNT,
    output logic [1:0]       STATE,
    output logic             HANG,
    output logic             BOOT_ERR,
    output logic             ALIGN_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HANG = 2'b10,
        ST_BAD  = 2'b11
    } state_e;

    localparam int               RUN_W   = $clog2(HANG_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HANG_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             is_stall;
    logic             is_seq;
    logic             misaligned;

    assign STATE = state;

    // The +4 test wraps modulo 2^PC_W, so the top word followed by 0 counts as sequential.
    always_comb begin
        is_stall   = (PC_IN == LAST_PC);
        is_seq     = (PC_IN == LAST_PC + PC_W'(4));
        misaligned = (PC_IN[1:0] != 2'b00);
        run_inc    = (run == RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            run       <= '0;
            LAST_PC   <= '0;
            SEQ_CNT   <= '0;
            STALL_CNT <= '0;
            JUMP_CNT  <= '0;
            HANG      <= 1'b0;
            BOOT_ERR  <= 1'b0;
            ALIGN_ERR <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (EN) begin
                        LAST_PC   <= PC_IN;
                        BOOT_ERR  <= (PC_IN != RESET_PC);
                        ALIGN_ERR <= ALIGN_ERR | misaligned;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN, ST_HANG: begin
                    if (EN) begin
                        LAST_PC   <= PC_IN;
                        ALIGN_ERR <= ALIGN_ERR | misaligned;
                        if (is_stall) begin
                            if (STALL_CNT != CNT_MAX) STALL_CNT <= STALL_CNT + CNT_W'(1);
                            run <= run_inc;
                            // Once the run is saturated every further stall keeps HANG asserted.
                            if (run_inc == RUN_MAX) begin
                                state <= ST_HANG;
                                HANG  <= 1'b1;
                            end
                        end else begin
                            run   <= '0;
                            state <= ST_RUN;
                            HANG  <= 1'b0;
                            if (is_seq) begin
                                if (SEQ_CNT != CNT_MAX) SEQ_CNT <= SEQ_CNT + CNT_W'(1);
                            end else begin
                                if (JUMP_CNT != CNT_MAX) JUMP_CNT <= JUMP_CNT + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    run   <= '0;
                    HANG  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: two instances (default and CNT_W=4/HANG_LIMIT=2) share one
// stimulus stream; a reference model feeds a per-cycle queue and directed checkpoints a second.
module tb_pc_trace_monitor;

    typedef struct packed {
        logic [31:0] last_pc;
        logic [15:0] seq;
        logic [15:0] stall;
        logic [15:0] jump;
        logic [1:0]  state;
        logic        hang;
        logic        boot;
        logic        align;
    } obs_t;

    localparam int OBS_W = $bits(obs_t);

    typedef struct {
        int   id;
        int   tag;
        obs_t e;
    } hand_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic [31:0] PC_IN = '0;

    logic [31:0] last0, last1;
    logic [15:0] seq0, stall0, jump0;
    logic [3:0]  seq1, stall1, jump1;
    logic [1:0]  state0, state1;
    logic        hang0, hang1, boot0, boot1, align0, align1;

    logic [OBS_W-1:0] exp_q[$];
    hand_t            hand_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // model state, index 0 = default instance, 1 = small instance
    logic [31:0] m_last[2];
    int          m_seq[2], m_stall[2], m_jump[2], m_run[2];
    logic [1:0]  m_state[2];
    logic        m_boot[2], m_align[2];
    int          cmax[2] = '{65535, 15};
    int          lim[2] = '{16, 2};

    // clock / reset
    always #5 CLK = ~CLK;

    pc_trace_monitor #(.PC_W(32), .RESET_PC(32'h0), .HANG_LIMIT(16), .CNT_W(16)) dut0 (
        .CLK(CLK), .RST(RST), .EN(EN), .PC_IN(PC_IN),
        .LAST_PC(last0), .SEQ_CNT(seq0), .STALL_CNT(stall0), .JUMP_CNT(jump0),
        .STATE(state0), .HANG(hang0), .BOOT_ERR(boot0), .ALIGN_ERR(align0)
    );

    pc_trace_monitor #(.PC_W(32), .RESET_PC(32'h0), .HANG_LIMIT(2), .CNT_W(4)) dut1 (
        .CLK(CLK), .RST(RST), .EN(EN), .PC_IN(PC_IN),
        .LAST_PC(last1), .SEQ_CNT(seq1), .STALL_CNT(stall1), .JUMP_CNT(jump1),
        .STATE(state1), .HANG(hang1), .BOOT_ERR(boot1), .ALIGN_ERR(align1)
    );

    function automatic obs_t mk(input logic [31:0] l, input int s, input int st, input int j,
                                input logic [1:0] sta, input logic h, input logic b, input logic a);
        obs_t o;
        o.last_pc = l;
        o.seq     = 16'(s);
        o.stall   = 16'(st);
        o.jump    = 16'(j);
        o.state   = sta;
        o.hang    = h;
        o.boot    = b;
        o.align   = a;
        return o;
    endfunction

    function automatic obs_t dut_obs(input int id);
        if (id == 0)
            return mk(last0, int'(seq0), int'(stall0), int'(jump0), state0, hang0, boot0, align0);
        return mk(last1, int'(seq1), int'(stall1), int'(jump1), state1, hang1, boot1, align1);
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [31:0] p);
        for (int id = 0; id < 2; id++) begin
            if (r) begin
                m_last[id] = '0; m_seq[id] = 0; m_stall[id] = 0; m_jump[id] = 0;
                m_run[id] = 0; m_state[id] = 2'b00; m_boot[id] = 1'b0; m_align[id] = 1'b0;
            end else if (e) begin
                if (m_state[id] == 2'b00) begin
                    m_boot[id]  = (p != 32'h0);
                    m_state[id] = 2'b01;
                end else if (p == m_last[id]) begin
                    if (m_stall[id] < cmax[id]) m_stall[id]++;
                    if (m_run[id] < lim[id]) m_run[id]++;
                    if (m_run[id] == lim[id]) m_state[id] = 2'b10;
                end else begin
                    if (p == m_last[id] + 32'd4) begin
                        if (m_seq[id] < cmax[id]) m_seq[id]++;
                    end else begin
                        if (m_jump[id] < cmax[id]) m_jump[id]++;
                    end
                    m_run[id]   = 0;
                    m_state[id] = 2'b01;
                end
                if (p[1:0] != 2'b00) m_align[id] = 1'b1;
                m_last[id] = p;
            end
            exp_q.push_back(mk(m_last[id], m_seq[id], m_stall[id], m_jump[id], m_state[id],
                               m_state[id] == 2'b10, m_boot[id], m_align[id]));
        end
    endtask

    // driver: one sample per call, inputs released after the edge
    task automatic step(input logic r, input logic e, input logic [31:0] p);
        @(negedge CLK);
        #1;
        RST   = r;
        EN    = e;
        PC_IN = p;
        model_step(r, e, p);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        EN  = 1'b0;
    endtask

    task automatic hand(input int id, input int tag, input obs_t e);
        hand_t h;
        h.id  = id;
        h.tag = tag;
        h.e   = e;
        hand_q.push_back(h);
    endtask

    // scoreboard monitor: every sampled cycle carries one expected record per instance
    always @(negedge CLK) begin
        obs_t  e, g;
        hand_t h;
        while (exp_q.size() >= 2) begin
            for (int id = 0; id < 2; id++) begin
                e = exp_q.pop_front();
                g = dut_obs(id);
                n_cmp++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL cycle%0d_dut%0d got=%h required=%h", cyc, id, g, e);
                end
            end
            cyc++;
        end
        while (hand_q.size() > 0) begin
            h = hand_q.pop_front();
            g = dut_obs(h.id);
            n_cmp++;
            if (g !== h.e) begin
                n_fail++;
                $display("FAIL check%0d_dut%0d got=%h required=%h", h.tag, h.id, g, h.e);
            end
        end
    end

    initial begin
        // reset state
        step(1'b1, 1'b0, 32'h0);
        hand(0, 0, mk(32'h0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0));

        // sequential stream from the boot PC
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h4);
        step(1'b0, 1'b1, 32'h8);
        step(1'b0, 1'b1, 32'hC);
        hand(0, 1, mk(32'hC, 3, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0));

        // wrong boot PC
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h10);
        hand(0, 2, mk(32'h10, 0, 0, 0, 2'b01, 1'b0, 1'b1, 1'b0));

        // hang after 16 stalls, still RUN after 15, exit on a jump
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 32'h0);
        hand(0, 3, mk(32'h0, 0, 15, 0, 2'b01, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 32'h0);
        hand(0, 4, mk(32'h0, 0, 16, 0, 2'b10, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, 32'h0);
        hand(0, 5, mk(32'h0, 0, 16, 0, 2'b10, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h40);
        hand(0, 6, mk(32'h40, 0, 17, 1, 2'b01, 1'b0, 1'b0, 1'b0));
        hand(1, 7, mk(32'h40, 0, 15, 1, 2'b01, 1'b0, 1'b0, 1'b0));

        // wrap-around sequential, misaligned jump, sticky alignment error
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h6);
        step(1'b0, 1'b1, 32'hA);
        hand(0, 8, mk(32'hA, 2, 0, 1, 2'b01, 1'b0, 1'b1, 1'b1));

        // EN gating, then reset together with EN mid-stream
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h4);
        step(1'b0, 1'b1, 32'h4);
        hand(0, 9, mk(32'h4, 1, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b1, 32'h8);
        hand(0, 10, mk(32'h0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 32'h4);
        hand(0, 11, mk(32'h4, 0, 0, 0, 2'b01, 1'b0, 1'b1, 1'b0));

        // counter saturation on the 4-bit instance
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        for (int k = 1; k <= 20; k++) step(1'b0, 1'b1, 32'(4 * k));
        hand(0, 12, mk(32'h50, 20, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0));
        hand(1, 13, mk(32'h50, 15, 0, 0, 2'b01, 1'b0, 1'b0, 1'b0));

        repeat (3) @(negedge CLK);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
